// File: rtl/fractal_sync_mp_rf_pkg.sv
// fractal_sync_pkg: shared types and helpers for the multi-port barrier register file.
package fractal_sync_pkg;

    localparam int unsigned MAX_LEVEL_WIDTH = 8;
    localparam int unsigned MAX_ID_WIDTH    = 16;

    // Entry layouts sized for the widest supported level/id fields.
    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } local_entry_t;

    typedef struct packed {
        logic                       valid;
        logic [MAX_LEVEL_WIDTH-1:0] level;
        logic [MAX_ID_WIDTH-1:0]    id;
    } remote_entry_t;

    typedef struct packed {
        logic present;
        logic bypass;
        logic err;
    } resp_t;

    function automatic int unsigned occ_width(input int unsigned n_regs);
        return $clog2(n_regs + 1);
    endfunction

endpackage

// File: rtl/fractal_sync_mp_rf_if.sv
// fractal_sync_mp_rf_if: per-port check requests and registered responses.
interface fractal_sync_mp_rf_if #(
    parameter int unsigned N_PORTS       = 2,
    parameter int unsigned N_LOCAL_REGS  = 2,
    parameter int unsigned N_REMOTE_REGS = 2,
    parameter int unsigned LEVEL_WIDTH   = 1,
    parameter int unsigned ID_WIDTH      = 1
);
    logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] level_i;
    logic [N_PORTS-1:0][ID_WIDTH-1:0]    id_i;
    logic [N_PORTS-1:0]                  check_local_i;
    logic [N_PORTS-1:0]                  check_remote_i;
    logic [N_PORTS-1:0]                  present_local_o;
    logic [N_PORTS-1:0]                  present_remote_o;
    logic [N_PORTS-1:0]                  bypass_local_o;
    logic [N_PORTS-1:0]                  bypass_remote_o;
    logic [N_PORTS-1:0]                  id_err_o;
    logic [N_PORTS-1:0]                  sig_err_o;
    logic [fractal_sync_pkg::occ_width(N_LOCAL_REGS)-1:0]  local_occ_o;
    logic [fractal_sync_pkg::occ_width(N_REMOTE_REGS)-1:0] remote_occ_o;

    modport master (
        output level_i, id_i, check_local_i, check_remote_i,
        input  present_local_o, present_remote_o, bypass_local_o, bypass_remote_o,
        input  id_err_o, sig_err_o, local_occ_o, remote_occ_o
    );

    modport slave (
        input  level_i, id_i, check_local_i, check_remote_i,
        output present_local_o, present_remote_o, bypass_local_o, bypass_remote_o,
        output id_err_o, sig_err_o, local_occ_o, remote_occ_o
    );
endinterface

// File: rtl/fractal_sync_mp_rf_cam.sv
// fractal_sync_mp_cam: multi-port toggle CAM; a hit frees the entry, a miss allocates
// the lowest free one, ports resolved in ascending order within a cycle.
module fractal_sync_mp_cam
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned N_REGS    = 2,
    parameter int unsigned TAG_WIDTH = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic [N_PORTS-1:0]                    check_i,
    input  logic [N_PORTS-1:0][TAG_WIDTH-1:0]     tag_i,
    output resp_t [N_PORTS-1:0]                   resp_o,
    output logic [occ_width(N_REGS)-1:0]          occ_o
);
    localparam int unsigned OCC_W = occ_width(N_REGS);

    logic [N_REGS-1:0]    valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q [N_REGS];
    logic [TAG_WIDTH-1:0] tag_d [N_REGS];
    logic [N_PORTS-1:0]   alloc_oh [N_REGS];
    resp_t [N_PORTS-1:0]  resp_q, resp_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 done;

    // alloc_oh remembers which port allocated an entry this cycle, so a later
    // hit on that entry can flag the allocator with bypass.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        resp_d  = '0;
        occ_d   = '0;
        done    = 1'b0;
        for (int r = 0; r < N_REGS; r++) alloc_oh[r] = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            done = !check_i[p] || clear_i;
            for (int r = 0; r < N_REGS; r++) begin
                if (!done && valid_d[r] && tag_d[r] == tag_i[p]) begin
                    done              = 1'b1;
                    valid_d[r]        = 1'b0;
                    resp_d[p].present = 1'b1;
                    for (int q = 0; q < N_PORTS; q++) resp_d[q].bypass = resp_d[q].bypass | alloc_oh[r][q];
                    alloc_oh[r]       = '0;
                end
            end
            for (int r = 0; r < N_REGS; r++) begin
                if (!done && !valid_d[r]) begin
                    done           = 1'b1;
                    valid_d[r]     = 1'b1;
                    tag_d[r]       = tag_i[p];
                    alloc_oh[r]    = '0;
                    alloc_oh[r][p] = 1'b1;
                end
            end
            resp_d[p].err = !done;
        end
        if (clear_i) valid_d = '0;
        for (int r = 0; r < N_REGS; r++) occ_d = occ_d + OCC_W'(valid_d[r]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            resp_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            resp_q  <= resp_d;
            occ_q   <= occ_d;
        end
    end

    // Tags are only meaningful under a valid bit, so they need no reset.
    always_ff @(posedge clk_i) tag_q <= tag_d;

    assign resp_o = resp_q;
    assign occ_o  = occ_q;
endmodule

// File: rtl/fractal_sync_mp_rf.sv
// fractal_sync_mp_rf: local (id-tagged) and remote (level+id-tagged) barrier CAMs.
module fractal_sync_mp_rf
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS       = 2,
    parameter int unsigned N_LOCAL_REGS  = 2,
    parameter int unsigned N_REMOTE_REGS = 2,
    parameter int unsigned LEVEL_WIDTH   = 1,
    parameter int unsigned ID_WIDTH      = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    fractal_sync_mp_rf_if.slave  bus
);
    logic [N_PORTS-1:0][LEVEL_WIDTH+ID_WIDTH-1:0] rtag;
    resp_t [N_PORTS-1:0]                          lresp, rresp;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign rtag[i]                 = {bus.level_i[i], bus.id_i[i]};
        assign bus.present_local_o[i]  = lresp[i].present;
        assign bus.bypass_local_o[i]   = lresp[i].bypass;
        assign bus.id_err_o[i]         = lresp[i].err;
        assign bus.present_remote_o[i] = rresp[i].present;
        assign bus.bypass_remote_o[i]  = rresp[i].bypass;
        assign bus.sig_err_o[i]        = rresp[i].err;
    end

    fractal_sync_mp_cam #(
        .N_PORTS   (N_PORTS),
        .N_REGS    (N_LOCAL_REGS),
        .TAG_WIDTH (ID_WIDTH)
    ) u_local (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .check_i (bus.check_local_i),
        .tag_i   (bus.id_i),
        .resp_o  (lresp),
        .occ_o   (bus.local_occ_o)
    );

    fractal_sync_mp_cam #(
        .N_PORTS   (N_PORTS),
        .N_REGS    (N_REMOTE_REGS),
        .TAG_WIDTH (LEVEL_WIDTH + ID_WIDTH)
    ) u_remote (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .check_i (bus.check_remote_i),
        .tag_i   (rtag),
        .resp_o  (rresp),
        .occ_o   (bus.remote_occ_o)
    );
endmodule
